// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand sequencer and its flag generator.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_OUT    = 3'd4
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
  } alu_flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative/carry generation for the 8-bit adder/subtractor.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  input  logic [DATA_W-1:0] sum,
  output alu_flags_t        flags
);

  // Subtraction is A + ~B + 1, so carry-out set means no borrow occurred.
  logic [DATA_W:0] carry_sum;

  assign carry_sum = {1'b0, a} + {1'b0, b ^ {DATA_W{sub}}} + {{DATA_W{1'b0}}, sub};

  assign flags.z = (sum == '0);
  assign flags.n = sum[DATA_W-1];
  assign flags.c = (carry_sum > {1'b0, {DATA_W{1'b1}}});

endmodule

// File: rtl/alu_operand_sequencer.sv
// Register front/back end around the stateless adder: loads A then B, captures the sum.
// Optional flag register is enabled by defining ALU_SEQ_FLAGS_EN.
module alu_operand_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_start,
  input  logic              op_sub,
  input  logic              op_abort,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              bus_valid,
  output logic              bus_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_sub,
  input  logic [DATA_W-1:0] alu_sum,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_sub_q, alu_sub_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              exec_fire;

  always_comb begin
    // NOTE: every signal gets a hold default up front so no path through the case infers a latch.
    state_d   = state_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sub_d = alu_sub_q;
    res_d     = res_q;
    exec_fire = 1'b0;

    // Abort wins over every transition and leaves operands, result and flags untouched.
    if (op_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            alu_sub_d = op_sub;
            state_d   = ST_LOAD_A;
          end
        end
        ST_LOAD_A: begin
          if (bus_valid) begin
            alu_a_d = bus_in;
            state_d = ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (bus_valid) begin
            alu_b_d = bus_in;
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_d     = alu_sum;
          exec_fire = 1'b1;
          state_d   = ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sub_q <= 1'b0;
      res_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
      state_q   <= state_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_sub_q <= alu_sub_d;
      res_q     <= res_d;
    end
  end

  assign bus_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign res_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sub   = alu_sub_q;
  assign res_data  = res_q;

`ifdef ALU_SEQ_FLAGS_EN
  alu_flags_t flags_q, flags_d, flags_new;

  alu_flag_gen u_flag_gen (
    .a     (alu_a_q),
    .b     (alu_b_q),
    .sub   (alu_sub_q),
    .sum   (alu_sum),
    .flags (flags_new)
  );

  always_comb begin
    flags_d = flags_q;
    if (exec_fire) flags_d = flags_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_c = flags_q.c;
`else
  // Flags compiled out: outputs are constant and the EXEC strobe has no consumer.
  logic unused_exec_fire;
  assign unused_exec_fire = exec_fire;
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed, table-driven bench for alu_operand_sequencer with an ideal adder model.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_start, op_sub, op_abort;
  logic [7:0] bus_in;
  logic       bus_valid, bus_ready;
  logic [7:0] alu_a, alu_b;
  logic       alu_sub;
  logic [7:0] alu_sum;
  logic [7:0] res_data;
  logic       res_valid, res_ready, busy;
  logic       flag_z, flag_n, flag_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic [2:0] znc;
    int         gap;
    int         bp;
  } vec_t;

  vec_t       vecs[4];
  vec_t       v_abort_next, v_reset_op, v_after_reset;
  logic [7:0] model_b;
  logic [2:0] model_flags;

  alu_operand_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_start  (op_start),
    .op_sub    (op_sub),
    .op_abort  (op_abort),
    .bus_in    (bus_in),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sub   (alu_sub),
    .alu_sum   (alu_sum),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c)
  );

  // External combinational adder/subtractor.
  assign alu_sum = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);

  always #5 clk = ~clk;

  function automatic logic [2:0] fl(input logic [2:0] f);
`ifdef ALU_SEQ_FLAGS_EN
    return f;
`else
    return 3'b000;
`endif
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    op_start = 1'b1;
    op_sub   = v.sub;
    tick();
    op_start = 1'b0;
    op_sub   = 1'b0;
    check("start_busy", 16'(busy), 16'd1);
    check("start_bus_ready", 16'(bus_ready), 16'd1);
    check("start_alu_sub", 16'(alu_sub), 16'(v.sub));

    bus_in    = v.a;
    bus_valid = 1'b1;
    tick();
    bus_valid = 1'b0;
    bus_in    = 8'hAA;
    check("a_capture", 16'(alu_a), 16'(v.a));
    check("loadb_bus_ready", 16'(bus_ready), 16'd1);

    // Idle bus plus a stray op_start: neither may disturb the operands.
    for (int g = 0; g < v.gap; g++) begin
      op_start = 1'b1;
      op_sub   = ~v.sub;
      tick();
      check("gap_alu_b", 16'(alu_b), 16'(model_b));
      check("gap_alu_sub", 16'(alu_sub), 16'(v.sub));
      check("gap_res_valid", 16'(res_valid), 16'd0);
    end
    op_start = 1'b0;
    op_sub   = 1'b0;

    bus_in    = v.b;
    bus_valid = 1'b1;
    res_ready = (v.bp == 0);
    tick();
    bus_valid = 1'b0;
    model_b   = v.b;
    check("b_capture", 16'(alu_b), 16'(v.b));
    check("exec_bus_ready", 16'(bus_ready), 16'd0);
    check("exec_res_valid", 16'(res_valid), 16'd0);
    check("exec_flags_hold", 16'({flag_z, flag_n, flag_c}), 16'(model_flags));

    tick();
    model_flags = fl(v.znc);
    check("out_res_valid", 16'(res_valid), 16'd1);
    check("out_res_data", 16'(res_data), 16'(v.sum));
    check("out_flags", 16'({flag_z, flag_n, flag_c}), 16'(model_flags));

    for (int i = 0; i < v.bp; i++) begin
      tick();
      check("hold_res_valid", 16'(res_valid), 16'd1);
      check("hold_res_data", 16'(res_data), 16'(v.sum));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("done_busy", 16'(busy), 16'd0);
    check("done_res_valid", 16'(res_valid), 16'd0);
    check("done_flags_hold", 16'({flag_z, flag_n, flag_c}), 16'(model_flags));
  endtask

  initial begin
    vecs[0] = '{sub: 1'b0, a: 8'h05, b: 8'h03, sum: 8'h08, znc: 3'b000, gap: 0, bp: 0};
    vecs[1] = '{sub: 1'b1, a: 8'h05, b: 8'h05, sum: 8'h00, znc: 3'b101, gap: 0, bp: 0};
    vecs[2] = '{sub: 1'b1, a: 8'h03, b: 8'h05, sum: 8'hFE, znc: 3'b010, gap: 0, bp: 0};
    vecs[3] = '{sub: 1'b0, a: 8'hFF, b: 8'h01, sum: 8'h00, znc: 3'b101, gap: 3, bp: 4};
    v_abort_next  = '{sub: 1'b0, a: 8'h02, b: 8'h02, sum: 8'h04, znc: 3'b000, gap: 0, bp: 0};
    v_reset_op    = '{sub: 1'b0, a: 8'h40, b: 8'h01, sum: 8'h41, znc: 3'b000, gap: 0, bp: 0};
    v_after_reset = '{sub: 1'b1, a: 8'h80, b: 8'h01, sum: 8'h7F, znc: 3'b001, gap: 1, bp: 1};

    rst_n = 1'b0; op_start = 1'b0; op_sub = 1'b0; op_abort = 1'b0;
    bus_in = 8'h00; bus_valid = 1'b0; res_ready = 1'b0;
    model_b = 8'h00; model_flags = 3'b000;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          16'({bus_ready, res_valid, busy, alu_sub, flag_z, flag_n, flag_c}), 16'd0);
    check("reset_res_data", 16'(res_data), 16'd0);
    check("reset_alu_ab", {alu_a, alu_b}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_bus_ready", 16'(bus_ready), 16'd0);

    for (int i = 0; i < 4; i++) run_op(vecs[i]);

    // Abort while waiting for operand B, with a valid operand on the bus that edge.
    op_start = 1'b1;
    op_sub   = 1'b1;
    tick();
    op_start  = 1'b0;
    bus_in    = 8'h10;
    bus_valid = 1'b1;
    tick();
    check("abort_a_capture", 16'(alu_a), 16'h0010);
    bus_in   = 8'h77;
    op_abort = 1'b1;
    tick();
    op_abort  = 1'b0;
    bus_valid = 1'b0;
    op_sub    = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_bus_ready", 16'(bus_ready), 16'd0);
    check("abort_alu_b_kept", 16'(alu_b), 16'(model_b));
    check("abort_alu_a_kept", 16'(alu_a), 16'h0010);
    check("abort_alu_sub_kept", 16'(alu_sub), 16'd1);
    check("abort_res_data_kept", 16'(res_data), 16'(vecs[3].sum));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_res_valid", 16'(res_valid), 16'd0);
      check("abort_flags_kept", 16'({flag_z, flag_n, flag_c}), 16'(model_flags));
    end
    run_op(v_abort_next);

    // Reset while the result is on offer.
    op_start = 1'b1;
    op_sub   = v_reset_op.sub;
    tick();
    op_start  = 1'b0;
    bus_in    = v_reset_op.a;
    bus_valid = 1'b1;
    tick();
    bus_in = v_reset_op.b;
    tick();
    bus_valid = 1'b0;
    tick();
    check("rst_pre_res_valid", 16'(res_valid), 16'd1);
    check("rst_pre_res_data", 16'(res_data), 16'(v_reset_op.sum));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_ctrl",
          16'({bus_ready, res_valid, busy, alu_sub, flag_z, flag_n, flag_c}), 16'd0);
    check("rst_async_res_data", 16'(res_data), 16'd0);
    check("rst_async_alu_ab", {alu_a, alu_b}, 16'd0);
    model_b     = 8'h00;
    model_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_idle_busy", 16'(busy), 16'd0);
    run_op(v_after_reset);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Multi-cycle front/back end for the 8-bit adder/subtractor datapath. It collects operand A and then operand B from the shared 8-bit bus using a valid/ready handshake, and presents both operands plus the subtract select to the combinational adder. It then captures the adder's sum into a result register with status flags, and offers the result downstream with a valid/ready handshake. The block sits between the system bus and the adder, owning every register around the otherwise stateless arithmetic.

## Interface
- `DATA_W`, 8, operand/result width (fixed at 8 for this CPU; parameter exists for the package constant only)
- `clk` input 1: single system clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `op_start` input 1: start an operation; sampled only in IDLE
- `op_sub` input 1: operation select captured with `op_start` (1 = A−B, 0 = A+B)
- `op_abort` input 1: return to IDLE from any state
- `bus_in` input 8: operand data
- `bus_valid` input 1: `bus_in` holds a valid operand
- `bus_ready` output 1: block accepts an operand this cycle
- `alu_a` output 8: operand A to adder
- `alu_b` output 8: operand B to adder
- `alu_sub` output 1: subtract select to adder
- `alu_sum` input 8: adder sum (combinational from `alu_a`/`alu_b`/`alu_sub`)
- `res_data` output 8: registered result
- `res_valid` output 1: `res_data` is valid
- `res_ready` input 1: consumer accepts the result
- `busy` output 1: state ≠ IDLE
- `flag_z`, `flag_n`, `flag_c` output 1 each: zero, negative, carry of the last completed operation

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, OUT.
- **IDLE**: `bus_ready`=0, `res_valid`=0. If `op_start`=1, capture `op_sub` into `alu_sub` and go to LOAD_A.
- **LOAD_A**: `bus_ready`=1. When `bus_valid` is high, capture `bus_in` into `alu_a` and go to LOAD_B.
- **LOAD_B**: `bus_ready`=1. When `bus_valid` is high, capture `bus_in` into `alu_b` and go to EXEC.
- **EXEC**: one cycle. Capture `alu_sum` into `res_data`, update the flags, and go to OUT.
- **OUT**: `res_valid`=1 and `res_data` is held stable. When `res_ready` is high, go to IDLE.
- `op_start` is ignored outside IDLE. `bus_valid` is ignored when `bus_ready`=0.
- `op_abort` has priority over every transition and forces IDLE on the next edge.
  - The result and flags are not modified.
  - `alu_a`, `alu_b` and `alu_sub` keep their values.
- Flag rules:
  - Z = (sum == 0).
  - N = sum[7].
  - C = bit 8 of {0,A} + {0,B ^ {8{sub}}} + sub. For subtraction, C=1 means no borrow.
- Flags update only in EXEC and hold otherwise.
- Arithmetic is modulo 256; no overflow flag.

## Timing
- Reset value of every output: 0. The state resets to IDLE.
- Reset asserted mid-operation discards the operation immediately (asynchronously).
- Per-operand accept: one edge with `bus_valid`&&`bus_ready`.
- Result latency: B is accepted at edge k, `res_data`/flags are captured at edge k+1, and `res_valid` is high from edge k+1.
- Minimum operation length:
  - `op_start` sampled at edge 0, A at edge 1, B at edge 2, result at edge 3.
  - Earliest result handshake at edge 4, back in IDLE after edge 4.
  - A new `op_start` is sampled at edge 5 at the earliest.
- `res_valid` may not drop without a handshake, except on `op_abort` or reset.
- `op_abort` in the same cycle as a result handshake: the transfer counts as completed, and the state goes to IDLE.

## Configuration
- `ALU_SEQ_FLAGS_EN` defined: the flag register and logic are present as specified.
- `ALU_SEQ_FLAGS_EN` undefined: `flag_z`, `flag_n` and `flag_c` are tied to 0 and no flag flops are synthesized. All other behaviour is unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the `DATA_W` constant (8);
  - the state enum typedef (IDLE, LOAD_A, LOAD_B, EXEC, OUT);
  - a flag struct typedef {z, n, c}.
- One sub-module, `alu_flag_gen`: combinational. It takes A, B, sub and sum and produces the flag struct. It is instantiated only under `ALU_SEQ_FLAGS_EN`.

## Test plan
- Add: `op_sub`=0, A=0x05, B=0x03 → `res_data`=0x08, Z=0, N=0, C=0; `res_valid` high one edge after B is accepted.
- Subtract to zero: `op_sub`=1, A=0x05, B=0x05 → `res_data`=0x00, Z=1, N=0, C=1.
- Borrow: `op_sub`=1, A=0x03, B=0x05 → `res_data`=0xFE, Z=0, N=1, C=0.
- Wrap plus back-pressure: A=0xFF, B=0x01, add, `res_ready` held low 4 cycles → `res_data`=0x00 with Z=1, C=1, held stable with `res_valid`=1 throughout; IDLE after the handshake. Also gap `bus_valid` low 3 cycles between A and B and check no operand is captured during the gap.
- Abort in LOAD_B (after A=0x10 accepted): `op_abort` pulse → `busy`=0 next cycle, `res_valid` never asserts, flags keep their prior values; the next operation (0x02+0x02) yields 0x04.
- Reset mid-EXEC/OUT: deassert `rst_n` → all outputs are 0 asynchronously, the state is IDLE, and a subsequent operation completes normally.
